pmp_check_pipe: RTL

- Multi-entry, pipelined PMP checker: a configuration table of NR_ENTRIES regions plus a 2-stage request pipeline that returns allow/deny for each physical access.
- Per-entry NAPOT/NA4 base and mask are precomputed into registers when configuration changes, keeping the request path to compare logic.
- Sits between the MMU/LSU/fetch and the memory interface; successor to the single-entry matcher, adding priority resolution, R/W/X permissions, lock semantics, privilege handling and a valid/ready handshake.

---
 rtl/pmp_check_pipe_if.sv | 30 +++
 rtl/pmp_check_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_check_pipe_if.sv
// Request/response handshake bundle for pmp_check_pipe.
// Signal directions in the names are from the checker's (slave's) point of view.
interface pmp_check_pipe_if #(
    parameter int unsigned PLEN     = 56,
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned IDX_W    = 4
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [PLEN-1:0]     req_addr_i;
    logic [1:0]          req_acc_i;
    logic                req_mmode_i;
    logic [ID_WIDTH-1:0] req_id_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic                rsp_allow_o;
    logic                rsp_hit_o;
    logic [IDX_W-1:0]    rsp_entry_o;
    logic [ID_WIDTH-1:0] rsp_id_o;

    modport master (
        output req_valid_i, req_addr_i, req_acc_i, req_mmode_i, req_id_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_hit_o, rsp_entry_o, rsp_id_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_acc_i, req_mmode_i, req_id_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_hit_o, rsp_entry_o, rsp_id_o
    );
endinterface

// File: rtl/pmp_check_pipe.sv
// Multi-entry PMP checker: config table with precomputed NA4/NAPOT base/mask and a
// two-stage (request, result) valid/ready pipeline returning allow/hit/entry per access.
module pmp_check_pipe #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned ID_WIDTH   = 4,
    localparam int unsigned IdxW      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_we_i,
    input  logic [IdxW-1:0]    cfg_idx_i,
    input  logic [PMP_LEN-1:0] cfg_addr_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [2:0]         cfg_perm_i,
    input  logic               cfg_lock_i,
    pmp_check_pipe_if.slave    bus_io
);
    localparam logic [1:0] ModeOff   = 2'd0;
    localparam logic [1:0] ModeTor   = 2'd1;
    localparam logic [1:0] ModeNa4   = 2'd2;
    localparam logic [1:0] ModeNapot = 2'd3;

    typedef enum logic [0:0] {StIdle, StUpd} state_e;

    state_e state_q;

    logic [PMP_LEN-1:0] addr_q [NR_ENTRIES];
    logic [1:0]         mode_q [NR_ENTRIES];
    logic [2:0]         perm_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] lock_q;
    logic [PLEN-1:0]    base_q [NR_ENTRIES];
    logic [PLEN-1:0]    mask_q [NR_ENTRIES];
    logic [PLEN-1:0]    base_d [NR_ENTRIES];
    logic [PLEN-1:0]    mask_d [NR_ENTRIES];

    logic [NR_ENTRIES:0] tor_lock;
    logic                cfg_ok;
    logic                addr_frozen;

    function automatic int unsigned trailing_ones(logic [PMP_LEN-1:0] a);
        int unsigned k = 0;
        for (int unsigned j = 0; j < PMP_LEN; j++) begin
            if (a[j] && k == j) k++;
        end
        return k;
    endfunction

    // Entry i's address is frozen when entry i+1 is a locked TOR (it is i+1's lower bound).
    always_comb begin
        tor_lock = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            tor_lock[i] = lock_q[i] && (mode_q[i] == ModeTor);
        end
        cfg_ok      = 1'b0;
        addr_frozen = 1'b0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (IdxW'(i) == cfg_idx_i) begin
                cfg_ok      = !lock_q[i];
                addr_frozen = tor_lock[i+1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                addr_q[i] <= '0;
                mode_q[i] <= ModeOff;
                perm_q[i] <= '0;
            end
            lock_q <= '0;
        end else if (cfg_we_i && cfg_ok) begin
            mode_q[cfg_idx_i] <= cfg_mode_i;
            perm_q[cfg_idx_i] <= cfg_perm_i;
            lock_q[cfg_idx_i] <= cfg_lock_i;
            if (!addr_frozen) addr_q[cfg_idx_i] <= cfg_addr_i;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            mask_d[i] = '0;
            unique case (mode_q[i])
                ModeNa4:   mask_d[i] = {PLEN{1'b1}} << 2;
                ModeNapot: begin
                    if (trailing_ones(addr_q[i]) == PMP_LEN) mask_d[i] = '0;
                    else mask_d[i] = {PLEN{1'b1}} << (trailing_ones(addr_q[i]) + 32'd3);
                end
                default:   mask_d[i] = '0;
            endcase
            base_d[i] = PLEN'({addr_q[i], 2'b00}) & mask_d[i];
        end
    end

    // FSM: UPD refreshes base/mask from the (already written) table; a write during UPD
    // keeps it in UPD so the newest write is also folded in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: if (cfg_we_i) state_q <= StUpd;
                StUpd: begin
                    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                        base_q[i] <= base_d[i];
                        mask_q[i] <= mask_d[i];
                    end
                    if (!cfg_we_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Pipeline stage A (request) and B (result).
    logic                a_valid_q;
    logic [PLEN-1:0]     a_addr_q;
    logic [1:0]          a_acc_q;
    logic                a_mmode_q;
    logic [ID_WIDTH-1:0] a_id_q;
    logic                b_valid_q;
    logic                b_allow_q;
    logic                b_hit_q;
    logic [IdxW-1:0]     b_entry_q;
    logic [ID_WIDTH-1:0] b_id_q;

    logic b_adv;
    logic a_free;
    logic accept;

    assign b_adv  = !b_valid_q || bus_io.rsp_ready_i;
    assign a_free = !a_valid_q || b_adv;
    assign bus_io.req_ready_o = a_free && !cfg_we_i && (state_q == StIdle);
    assign accept = bus_io.req_valid_i && bus_io.req_ready_o;

    logic [NR_ENTRIES-1:0] match;
    logic                  hit_d;
    logic [IdxW-1:0]       entry_d;
    logic [2:0]            perm_sel;
    logic                  lock_sel;
    logic                  perm_bit;
    logic                  allow_d;

    always_comb begin
        logic [PLEN-1:0] prev;
        logic [PLEN-1:0] cur;
        prev  = '0;
        match = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            cur = PLEN'({addr_q[i], 2'b00});
            unique case (mode_q[i])
                ModeTor:           match[i] = (a_addr_q >= prev) && (a_addr_q < cur);
                ModeNa4, ModeNapot: match[i] = (a_addr_q & mask_q[i]) == base_q[i];
                default:           match[i] = 1'b0;
            endcase
            prev = cur;
        end
    end

    // Scan downward so the lowest-index match is the one left standing.
    always_comb begin
        hit_d    = 1'b0;
        entry_d  = '0;
        perm_sel = '0;
        lock_sel = 1'b0;
        for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_d    = 1'b1;
                entry_d  = IdxW'(i);
                perm_sel = perm_q[i];
                lock_sel = lock_q[i];
            end
        end
        unique case (a_acc_q)
            2'd0:    perm_bit = perm_sel[0];
            2'd1:    perm_bit = perm_sel[1];
            2'd2:    perm_bit = perm_sel[2];
            default: perm_bit = 1'b0;
        endcase
        if (a_acc_q == 2'd3)                allow_d = 1'b0;
        else if (!hit_d)                    allow_d = a_mmode_q;
        else if (a_mmode_q && !lock_sel)    allow_d = 1'b1;
        else                                allow_d = perm_bit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
            a_acc_q   <= '0;
            a_mmode_q <= 1'b0;
            a_id_q    <= '0;
            b_valid_q <= 1'b0;
            b_allow_q <= 1'b0;
            b_hit_q   <= 1'b0;
            b_entry_q <= '0;
            b_id_q    <= '0;
        end else begin
            if (accept) begin
                a_valid_q <= 1'b1;
                a_addr_q  <= bus_io.req_addr_i;
                a_acc_q   <= bus_io.req_acc_i;
                a_mmode_q <= bus_io.req_mmode_i;
                a_id_q    <= bus_io.req_id_i;
            end else if (b_adv) begin
                a_valid_q <= 1'b0;
            end
            if (b_adv) begin
                b_valid_q <= a_valid_q;
                if (a_valid_q) begin
                    b_allow_q <= allow_d;
                    b_hit_q   <= hit_d;
                    b_entry_q <= entry_d;
                    b_id_q    <= a_id_q;
                end
            end
        end
    end

    assign bus_io.rsp_valid_o = b_valid_q;
    assign bus_io.rsp_allow_o = b_allow_q;
    assign bus_io.rsp_hit_o   = b_hit_q;
    assign bus_io.rsp_entry_o = b_entry_q;
    assign bus_io.rsp_id_o    = b_id_q;
endmodule
